// File: rtl/hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl
//   Sequencing controller for the 5-stage pipeline. It generates the
//   enable, flush and bubble controls for PC, IF/ID and ID/EX. It detects
//   load-use hazards and taken-branch flushes. It also sequences the
//   multi-cycle MULTU/DIVU unit and pulses the HI/LO write enable when the
//   result is ready.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   id_rs, id_rt      source register fields of the ID instruction
//   id_uses_rs/_rt    ID instruction actually reads rs / rt
//   ex_mem_read       instruction in EX is a load
//   ex_rt             destination register of that load
//   br_taken          branch/jump in ID resolved taken
//   id_md_start       ID instruction is MULTU/DIVU
//   id_md_read        ID instruction is MFHI/MFLO
//   en_pc, en_ifid    PC and IF/ID register enables
//   flush_ifid        clear IF/ID on the next edge
//   bubble_idex       load a NOP into ID/EX on the next edge
//   md_busy           multiply/divide unit occupied (RUN or DONE)
//   md_done           result valid this cycle
//   en_hilo           HI/LO write enable (written at the edge ending DONE)
//   md_cnt            remaining RUN cycles, 0 outside RUN (debug)
// ---------------------------------------------------------------------------
module hazard_stall_ctrl #(
  parameter int MD_CYCLES = 32,  // legal range 2..63
  parameter int CW        = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [4:0]    id_rs,
  input  logic [4:0]    id_rt,
  input  logic          id_uses_rs,
  input  logic          id_uses_rt,
  input  logic          ex_mem_read,
  input  logic [4:0]    ex_rt,
  input  logic          br_taken,
  input  logic          id_md_start,
  input  logic          id_md_read,
  output logic          en_pc,
  output logic          en_ifid,
  output logic          flush_ifid,
  output logic          bubble_idex,
  output logic          md_busy,
  output logic          md_done,
  output logic          en_hilo,
  output logic [CW-1:0] md_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // RUN counts cnt down from MD_CYCLES-1 to 0, giving MD_CYCLES RUN cycles.
  localparam logic [CW-1:0] CNT_LOAD = CW'(MD_CYCLES - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic rs_hit;
  logic rt_hit;
  logic load_use;
  logic md_hazard;
  logic stall;

  // -------------------------------------------------------------------------
  // Hazard detection (purely combinational)
  // -------------------------------------------------------------------------
  always_comb begin
    rs_hit    = id_uses_rs && (id_rs == ex_rt);
    rt_hit    = id_uses_rt && (id_rt == ex_rt);
    // $zero is never a real producer, so it cannot create a dependency.
    load_use  = ex_mem_read && (ex_rt != 5'd0) && (rs_hit || rt_hit);
    // Any HI/LO reader or a second MULTU/DIVU waits until the unit is IDLE.
    md_hazard = (id_md_start || id_md_read) && (state_q != IDLE);
    stall     = load_use || md_hazard;
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        // A start held back by a load-use stall is not accepted yet.
        if (id_md_start && !stall) begin
          state_d = RUN;
          cnt_d   = CNT_LOAD;
        end
      end
      RUN: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic
  // -------------------------------------------------------------------------
  always_comb begin
    en_pc       = 1'b1;
    en_ifid     = 1'b1;
    flush_ifid  = 1'b0;
    bubble_idex = 1'b0;
    md_busy     = 1'b0;
    md_done     = 1'b0;
    en_hilo     = 1'b0;
    md_cnt      = '0;

    if (!rst) begin
      if (stall) begin
        // Hold PC and IF/ID, inject a bubble. A taken branch in ID is
        // ignored here and re-resolves once the stall clears.
        en_pc       = 1'b0;
        en_ifid     = 1'b0;
        bubble_idex = 1'b1;
      end else begin
        flush_ifid  = br_taken;
      end

      md_busy = (state_q == RUN) || (state_q == DONE);
      md_done = (state_q == DONE);
      en_hilo = (state_q == DONE);
      md_cnt  = (state_q == RUN) ? cnt_q : '0;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_stall_ctrl
//   Scoreboard bench for hazard_stall_ctrl with MD_CYCLES=4. Each cycle the
//   inputs are driven just after posedge. The expected output vector, from
//   a cycle-count model of the MD unit, is pushed to a queue. It is popped
//   and compared at negedge.
// ---------------------------------------------------------------------------
module tb_hazard_stall_ctrl;
  localparam int MD = 4;
  localparam int CW = 6;
  localparam int OW = 7 + CW;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    id_rs, id_rt, ex_rt;
  logic          id_uses_rs, id_uses_rt, ex_mem_read, br_taken;
  logic          id_md_start, id_md_read;
  logic          en_pc, en_ifid, flush_ifid, bubble_idex;
  logic          md_busy, md_done, en_hilo;
  logic [CW-1:0] md_cnt;

  int checks = 0;
  int errors = 0;

  // Model: t = cycles since the MD start was accepted, 0 when idle.
  int t = 0;
  int hilo_after_abort = 0;

  logic [OW-1:0] exp_q[$];
  string         tag_q[$];

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.MD_CYCLES(MD), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .br_taken(br_taken),
    .id_md_start(id_md_start), .id_md_read(id_md_read),
    .en_pc(en_pc), .en_ifid(en_ifid),
    .flush_ifid(flush_ifid), .bubble_idex(bubble_idex),
    .md_busy(md_busy), .md_done(md_done), .en_hilo(en_hilo),
    .md_cnt(md_cnt)
  );

  task automatic chk(input string tag, input logic [OW-1:0] obs,
                     input logic [OW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (pc,ifid,flush,bub,busy,done,hilo,cnt)",
               tag, obs, exp);
    end
  endtask

  function automatic logic model_stall();
    logic lu, busy;
    lu   = ex_mem_read && ex_rt != 0 &&
           ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt));
    busy = (t >= 1);
    return lu || ((id_md_start || id_md_read) && busy);
  endfunction

  function automatic logic [OW-1:0] model_out();
    logic st, busy, done;
    logic [CW-1:0] c;
    if (rst) return {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, {CW{1'b0}}};
    st   = model_stall();
    busy = (t >= 1 && t <= MD + 1);
    done = (t == MD + 1);
    c    = (t >= 1 && t <= MD) ? CW'(MD - t) : '0;
    return {~st, ~st, (~st & br_taken), st, busy, done, done, c};
  endfunction

  task automatic model_edge();
    if (rst)                              t = 0;
    else if (t == 0)                      t = (id_md_start && !model_stall()) ? 1 : 0;
    else if (t == MD + 1)                 t = 0;
    else                                  t = t + 1;
  endtask

  // One cycle: push expectation, compare at negedge, advance at posedge.
  task automatic cyc(input string tag);
    logic [OW-1:0] obs;
    exp_q.push_back(model_out());
    tag_q.push_back(tag);
    @(negedge clk);
    obs = {en_pc, en_ifid, flush_ifid, bubble_idex, md_busy, md_done, en_hilo, md_cnt};
    chk(tag_q.pop_front(), obs, exp_q.pop_front());
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_in();
    id_rs = 0; id_rt = 0; ex_rt = 0;
    id_uses_rs = 0; id_uses_rt = 0; ex_mem_read = 0; br_taken = 0;
    id_md_start = 0; id_md_read = 0;
  endtask

  initial begin
    rst = 1'b1;
    idle_in();
    // Reset forces outputs, even with a load-use hazard present.
    ex_mem_read = 1; ex_rt = 8; id_rs = 8; id_uses_rs = 1;
    #1;
    cyc("reset_forced");
    cyc("reset_hold");
    rst = 1'b0;
    idle_in();
    cyc("post_reset_idle");

    // Load-use on rs, one cycle, then clears.
    ex_mem_read = 1; ex_rt = 8; id_rs = 8; id_uses_rs = 1;
    cyc("load_use_rs");
    ex_mem_read = 0;
    cyc("load_use_clear");
    // Load-use on rt.
    ex_mem_read = 1; ex_rt = 17; id_rt = 17; id_uses_rt = 1; id_uses_rs = 0;
    cyc("load_use_rt");
    idle_in();

    // Register 0 and unused operand never stall.
    ex_mem_read = 1; ex_rt = 0; id_rs = 0; id_uses_rs = 1;
    cyc("reg0_no_stall");
    ex_rt = 9; id_rt = 9; id_uses_rt = 0; id_rs = 3;
    cyc("unused_rt_no_stall");
    idle_in();

    // Branch flush and priority against load-use.
    br_taken = 1;
    cyc("br_flush");
    ex_mem_read = 1; ex_rt = 5; id_rs = 5; id_uses_rs = 1;
    cyc("br_vs_load_use");
    idle_in();

    // MD sequence with MFHI held from cycle 2 through cycle 6.
    id_md_start = 1;
    cyc("md_c0_start");
    id_md_start = 0;
    cyc("md_c1");
    id_md_read = 1;
    for (int i = 2; i <= 5; i++) cyc($sformatf("mfhi_stall_c%0d", i));
    cyc("mfhi_proceed_c6");
    id_md_read = 0;
    cyc("md_idle_c7");

    // MULTU held in ID during busy, accepted back to back at cycle 6.
    id_md_start = 1;
    cyc("b2b_c0_start");
    br_taken = 1;              // branch while busy: stalled, FSM unaffected
    for (int i = 1; i <= 5; i++) cyc($sformatf("b2b_stall_c%0d", i));
    br_taken = 0;
    cyc("b2b_accept_c6");
    id_md_start = 0;
    for (int i = 7; i <= 13; i++) cyc($sformatf("b2b_run_c%0d", i));

    // Load-use blocks acceptance in IDLE.
    id_md_start = 1; ex_mem_read = 1; ex_rt = 4; id_rs = 4; id_uses_rs = 1;
    cyc("start_blocked_by_lu");
    idle_in();
    cyc("start_not_taken");

    // Reset in the middle of RUN: no en_hilo pulse afterwards.
    id_md_start = 1;
    cyc("abort_c0_start");
    id_md_start = 0;
    cyc("abort_c1");
    cyc("abort_c2");
    rst = 1'b1;
    cyc("abort_c3_rst");
    rst = 1'b0;
    for (int i = 4; i <= 10; i++) begin
      if (en_hilo) hilo_after_abort++;
      cyc($sformatf("abort_after_c%0d", i));
    end
    chk("abort_no_hilo", OW'(hilo_after_abort), '0);

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      ex_mem_read = ($urandom_range(0, 2) == 0);
      ex_rt       = 5'($urandom_range(0, 3));
      id_rs       = 5'($urandom_range(0, 3));
      id_rt       = 5'($urandom_range(0, 3));
      id_uses_rs  = 1'($urandom_range(0, 1));
      id_uses_rt  = 1'($urandom_range(0, 1));
      br_taken    = ($urandom_range(0, 3) == 0);
      id_md_start = ($urandom_range(0, 5) == 0);
      id_md_read  = ($urandom_range(0, 5) == 0);
      rst         = ($urandom_range(0, 60) == 0);
      cyc("random");
    end
    rst = 1'b0;
    idle_in();
    cyc("final_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Pipeline sequencing controller for the 5-stage CPU. It drives the enable and flush/bubble controls of the PC, IF/ID and ID/EX pipeline registers. It detects load-use hazards and taken-branch flushes. It also runs the multi-cycle MULTU/DIVU unit and asserts the HI/LO register write enable when the result is ready.

Parameters:
MD_CYCLES, 32, execution cycles of the multiply/divide unit (legal range 2..63)
CW, 6, width of the internal cycle counter and the md_cnt output

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
id_rs  in  5  rs field of the instruction in ID
id_rt  in  5  rt field of the instruction in ID
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
ex_mem_read  in  1  EX instruction is a load
ex_rt  in  5  destination register of the EX load
br_taken  in  1  branch/jump in ID resolved taken
id_md_start  in  1  ID instruction is MULTU/DIVU
id_md_read  in  1  ID instruction is MFHI/MFLO
en_pc  out  1  PC register enable
en_ifid  out  1  IF/ID register enable
flush_ifid  out  1  clear IF/ID contents on the next edge
bubble_idex  out  1  load a NOP into ID/EX on the next edge
md_busy  out  1  multiply/divide unit occupied
md_done  out  1  result valid this cycle
en_hilo  out  1  HI/LO register write enable
md_cnt  out  CW  remaining RUN cycles (debug)

Behaviour:
- Reset: rst is sampled at posedge clk. On reset, state=IDLE and cnt=0.
- While rst is high, outputs are forced to: en_pc=1, en_ifid=1, flush_ifid=0, bubble_idex=0, md_busy=0, md_done=0, en_hilo=0, md_cnt=0.
- Reset mid-operation aborts any RUN or DONE sequence. No en_hilo pulse is issued.
- All pipeline-control outputs are combinational from state, cnt and the current inputs. There are no registered stall outputs.
- load_use = ex_mem_read && ex_rt!=0 && ((id_uses_rs && id_rs==ex_rt) || (id_uses_rt && id_rt==ex_rt)).
- md_hazard = (id_md_start || id_md_read) && state!=IDLE.
- stall = load_use || md_hazard.
- When stall=1: en_pc=0, en_ifid=0, bubble_idex=1, flush_ifid=0. br_taken is ignored; the branch re-evaluates when the stall clears.
- When stall=0: en_pc=1, en_ifid=1, bubble_idex=0, flush_ifid=br_taken.
- A register index of 0 never creates a load-use hazard.
- The load-use stall lasts exactly one cycle per hazard, because the load leaves EX.

FSM states: IDLE, RUN, DONE.
- IDLE:
  - If id_md_start && !stall, go to RUN and load cnt=MD_CYCLES-1. This is the acceptance edge.
  - Otherwise stay in IDLE.
- RUN:
  - If cnt==0, go to DONE.
  - Otherwise decrement cnt and stay in RUN.
  - RUN therefore lasts exactly MD_CYCLES cycles.
- DONE:
  - Lasts one cycle, then always returns to IDLE.
  - md_done=1 and en_hilo=1 during this cycle; HI/LO are written at the edge that ends DONE.
- md_busy=1 in RUN and DONE. md_cnt=cnt in RUN and 0 otherwise.
- MFHI/MFLO or a new MULTU/DIVU in ID stalls through RUN and DONE, and proceeds in the first IDLE cycle.
- A new start accepted in that IDLE cycle re-enters RUN with no gap.
- br_taken while the FSM is busy does not affect the FSM. A flush of a non-accepted MULTU in IF/ID is harmless.

Test Plan:
- Load-use: ex_mem_read=1, ex_rt=8, id_rs=8, id_uses_rs=1 for one cycle -> en_pc=0, en_ifid=0, bubble_idex=1 that cycle. Next cycle, with ex_mem_read=0, all three return to 1/1/0.
- Register-0 and unused operand: ex_rt=0 with id_rs=0; then ex_rt=9 with id_rt=9 and id_uses_rt=0 -> no stall in either case.
- Branch flush and priority: br_taken=1 with no hazard -> flush_ifid=1, en_pc=1. br_taken=1 together with load_use -> flush_ifid=0, stall asserted.
- MD sequence, MD_CYCLES=4: id_md_start at cycle 0 ->
  - md_busy=1 for cycles 1-5;
  - md_cnt=3,2,1,0 in cycles 1-4;
  - md_done=en_hilo=1 only in cycle 5;
  - back to IDLE in cycle 6.
- MFHI during busy: id_md_read=1 held from cycle 2 -> stall in cycles 2-5, en_pc=1 in cycle 6. A back-to-back MULTU in ID is accepted at cycle 6.
- Reset mid-RUN: rst=1 at cycle 3 -> next cycle state IDLE, md_busy=0, md_cnt=0, and no en_hilo pulse ever occurs.
